// File: rtl/fb_rect_writer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fb_rect_writer_pkg
//  Description : Shared framebuffer definitions used by the rectangle writer
//                and the display-side reader: default geometry, bank layout
//                and the writer state encoding.
//  Revision    : 1.0  initial release
// ============================================================================
package fb_rect_writer_pkg;

    // Default framebuffer geometry (1 bit per pixel)
    localparam int c_FB_WIDTH   = 320;
    localparam int c_FB_HEIGHT  = 200;

    // Four 16K x 1 block RAMs; a 16-bit linear address splits as bank/local
    localparam int c_FB_BANKS   = 4;
    localparam int c_FB_BANK_AW = 14;
    localparam int c_FB_LIN_AW  = 16;

    // Command coordinate widths
    localparam int c_FB_X_W     = 9;
    localparam int c_FB_Y_W     = 8;

    // Writer state encoding
    localparam int              c_ST_W     = 2;
    localparam logic [c_ST_W-1:0] c_ST_IDLE  = 2'd0;
    localparam logic [c_ST_W-1:0] c_ST_SETUP = 2'd1;
    localparam logic [c_ST_W-1:0] c_ST_DRAW  = 2'd2;
    localparam logic [c_ST_W-1:0] c_ST_DONE  = 2'd3;

endpackage
`default_nettype wire

// File: rtl/fb_addr_split.sv
`default_nettype none
// ============================================================================
//  Module      : fb_addr_split
//  Description : Splits a 16-bit linear framebuffer address into a one-hot
//                bank enable and a 14-bit bank-local address.
//  Ports       : i_en        - qualifies the bank enable (all zero when low)
//                i_lin       - linear pixel address
//                o_bank_we   - one-hot bank enable
//                o_addr      - bank-local address
//  Revision    : 1.0  initial release
// ============================================================================
module fb_addr_split
    import fb_rect_writer_pkg::*;
(
    input  logic                    i_en,
    input  logic [c_FB_LIN_AW-1:0]  i_lin,
    output logic [c_FB_BANKS-1:0]   o_bank_we,
    output logic [c_FB_BANK_AW-1:0] o_addr
);

    logic [c_FB_LIN_AW-c_FB_BANK_AW-1:0] w_bank;

    assign w_bank = i_lin[c_FB_LIN_AW-1:c_FB_BANK_AW];
    assign o_addr = i_lin[c_FB_BANK_AW-1:0];

    for (genvar b = 0; b < c_FB_BANKS; b++) begin : g_bank
        assign o_bank_we[b] = i_en && (w_bank == 2'(b));
    end

endmodule
`default_nettype wire

// File: rtl/fb_rect_writer.sv
`default_nettype none
// ============================================================================
//  Module      : fb_rect_writer
//  Description : Fills an inclusive rectangle of a 1-bpp framebuffer with a
//                constant colour, one pixel per clock, in raster order.
//  Ports       : clk, reset            - clock, synchronous active-high reset
//                cmd_valid/cmd_ready   - command handshake
//                cmd_x0/x1, cmd_y0/y1  - inclusive rectangle corners
//                cmd_color             - pixel value
//                busy, done            - status; done pulses for one cycle
//                fb_we/fb_addr/fb_din  - registered write port to 4 RAM banks
//  Revision    : 1.0  initial release
// ============================================================================
module fb_rect_writer
    import fb_rect_writer_pkg::*;
#(
    parameter int WIDTH  = c_FB_WIDTH,
    parameter int HEIGHT = c_FB_HEIGHT
)
(
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [c_FB_X_W-1:0]     cmd_x0,
    input  logic [c_FB_X_W-1:0]     cmd_x1,
    input  logic [c_FB_Y_W-1:0]     cmd_y0,
    input  logic [c_FB_Y_W-1:0]     cmd_y1,
    input  logic                    cmd_color,
    output logic                    busy,
    output logic                    done,
    output logic [c_FB_BANKS-1:0]   fb_we,
    output logic [c_FB_BANK_AW-1:0] fb_addr,
    output logic                    fb_din
);

    localparam logic [c_FB_X_W-1:0]    c_X_MAX    = c_FB_X_W'(WIDTH - 1);
    localparam logic [c_FB_Y_W-1:0]    c_Y_MAX    = c_FB_Y_W'(HEIGHT - 1);
    localparam logic [c_FB_LIN_AW-1:0] c_ROW_STEP = c_FB_LIN_AW'(WIDTH);

    logic [c_ST_W-1:0]       r_state;
    logic [c_ST_W-1:0]       w_state_nxt;

    // Latched command
    logic [c_FB_X_W-1:0]     r_x0;
    logic [c_FB_X_W-1:0]     r_x1;
    logic [c_FB_Y_W-1:0]     r_y0;
    logic [c_FB_Y_W-1:0]     r_y1;
    logic                    r_color;

    // Raster walk
    logic [c_FB_X_W-1:0]     r_x;
    logic [c_FB_Y_W-1:0]     r_y;
    logic [c_FB_LIN_AW-1:0]  r_row_base;
    logic                    r_drain;

    // Registered write port
    logic [c_FB_BANKS-1:0]   r_fb_we;
    logic [c_FB_BANK_AW-1:0] r_fb_addr;
    logic                    r_fb_din;

    logic [c_FB_X_W-1:0]     w_x1_clamp;
    logic [c_FB_Y_W-1:0]     w_y1_clamp;
    logic                    w_empty;
    logic [c_FB_LIN_AW-1:0]  w_row_base0;
    logic                    w_issue;
    logic                    w_last;
    logic [c_FB_LIN_AW-1:0]  w_lin;
    logic [c_FB_BANKS-1:0]   w_bank_we;
    logic [c_FB_BANK_AW-1:0] w_local_addr;

    // Clipping: x0/y0 beyond the last column/row fall out as "x0 > x1c" after
    // clamping, so a single pair of compares covers every empty case.
    assign w_x1_clamp  = (r_x1 > c_X_MAX) ? c_X_MAX : r_x1;
    assign w_y1_clamp  = (r_y1 > c_Y_MAX) ? c_Y_MAX : r_y1;
    assign w_empty     = (r_x0 > w_x1_clamp) || (r_y0 > w_y1_clamp) ||
                         (r_x0 > c_X_MAX)    || (r_y0 > c_Y_MAX);
    assign w_row_base0 = {{(c_FB_LIN_AW-c_FB_Y_W){1'b0}}, r_y0} * c_ROW_STEP;

    // DRAW lasts one cycle longer than the pixel count: the extra (drain)
    // cycle presents the final registered write, so DONE lands right after it.
    assign w_issue = (r_state == c_ST_DRAW) && !r_drain;
    assign w_last  = (r_x == r_x1) && (r_y == r_y1);
    assign w_lin   = r_row_base + {{(c_FB_LIN_AW-c_FB_X_W){1'b0}}, r_x};

    fb_addr_split u_addr_split (
        .i_en      (w_issue),
        .i_lin     (w_lin),
        .o_bank_we (w_bank_we),
        .o_addr    (w_local_addr)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE:  if (cmd_valid) w_state_nxt = c_ST_SETUP;
            c_ST_SETUP: w_state_nxt = w_empty ? c_ST_DONE : c_ST_DRAW;
            c_ST_DRAW:  if (r_drain) w_state_nxt = c_ST_DONE;
            c_ST_DONE:  w_state_nxt = c_ST_IDLE;
            default:    w_state_nxt = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_x0       <= '0;
            r_x1       <= '0;
            r_y0       <= '0;
            r_y1       <= '0;
            r_color    <= 1'b0;
            r_x        <= '0;
            r_y        <= '0;
            r_row_base <= '0;
            r_drain    <= 1'b0;
            r_fb_we    <= '0;
            r_fb_addr  <= '0;
            r_fb_din   <= 1'b0;
        end else begin
            // Bank enable is already gated by w_issue, so idle cycles write 0
            r_fb_we <= w_bank_we;
            case (r_state)
                c_ST_IDLE: begin
                    if (cmd_valid) begin
                        r_x0    <= cmd_x0;
                        r_x1    <= cmd_x1;
                        r_y0    <= cmd_y0;
                        r_y1    <= cmd_y1;
                        r_color <= cmd_color;
                    end
                end
                c_ST_SETUP: begin
                    r_x1       <= w_x1_clamp;
                    r_y1       <= w_y1_clamp;
                    r_row_base <= w_row_base0;
                    r_x        <= r_x0;
                    r_y        <= r_y0;
                    r_drain    <= 1'b0;
                end
                c_ST_DRAW: begin
                    if (w_issue) begin
                        r_fb_addr <= w_local_addr;
                        r_fb_din  <= r_color;
                        if (w_last) begin
                            r_drain <= 1'b1;
                        end else if (r_x == r_x1) begin
                            r_x        <= r_x0;
                            r_y        <= r_y + 1'b1;
                            r_row_base <= r_row_base + c_ROW_STEP;
                        end else begin
                            r_x <= r_x + 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign cmd_ready = (r_state == c_ST_IDLE);
    assign busy      = ~cmd_ready;
    assign done      = (r_state == c_ST_DONE);
    assign fb_we     = r_fb_we;
    assign fb_addr   = r_fb_addr;
    assign fb_din    = r_fb_din;

endmodule
`default_nettype wire

// File: tb/tb_fb_rect_writer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fb_rect_writer
//  Description : Scoreboard bench for fb_rect_writer. Each command pushes its
//                expected write/done events (with expected cycle) into a
//                queue; a negedge monitor pops and compares every event the
//                DUT presents.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_fb_rect_writer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [8:0]  cmd_x0 = '0;
    logic [8:0]  cmd_x1 = '0;
    logic [7:0]  cmd_y0 = '0;
    logic [7:0]  cmd_y1 = '0;
    logic        cmd_color = 1'b0;
    logic        busy;
    logic        done;
    logic [3:0]  fb_we;
    logic [13:0] fb_addr;
    logic        fb_din;

    fb_rect_writer dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_x0    (cmd_x0),
        .cmd_x1    (cmd_x1),
        .cmd_y0    (cmd_y0),
        .cmd_y1    (cmd_y1),
        .cmd_color (cmd_color),
        .busy      (busy),
        .done      (done),
        .fb_we     (fb_we),
        .fb_addr   (fb_addr),
        .fb_din    (fb_din)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit          is_done;
        logic [3:0]  we;
        logic [13:0] addr;
        logic        din;
        int          cyc;
    } ev_t;

    ev_t         q[$];
    ev_t         m_e;
    int          checks = 0;
    int          errors = 0;
    int          n_writes = 0;
    logic [3:0]  last_we = '0;
    logic [13:0] last_addr = '0;

    // Monitor: every write or done cycle must match the head of the queue
    always @(negedge clk) begin
        if (fb_we != 4'b0000 || done) begin
            if (fb_we != 4'b0000) begin
                n_writes++;
                last_we   = fb_we;
                last_addr = fb_addr;
            end
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_event cyc=%0d actual we=%b addr=%0d done=%b required no event",
                         cyc, fb_we, fb_addr, done);
            end else begin
                m_e = q.pop_front();
                if (m_e.is_done != done || m_e.cyc != cyc ||
                    (!m_e.is_done && (fb_we !== m_e.we || fb_addr !== m_e.addr || fb_din !== m_e.din))) begin
                    errors++;
                    $display("FAIL event cyc=%0d actual we=%b addr=%0d din=%b done=%b required we=%b addr=%0d din=%b done=%b cyc=%0d",
                             cyc, fb_we, fb_addr, fb_din, done,
                             m_e.we, m_e.addr, m_e.din, m_e.is_done, m_e.cyc);
                end
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Expected events for a command accepted at the edge that starts cycle k.
    // limit < 0: all writes plus done; otherwise only the first 'limit' writes.
    task automatic push_cmd(input int x0, input int x1, input int y0, input int y1,
                            input bit color, input int limit, input int k);
        int  x1c;
        int  y1c;
        int  n;
        int  lin;
        bit  empty;
        ev_t e;
        x1c   = (x1 > 319) ? 319 : x1;
        y1c   = (y1 > 199) ? 199 : y1;
        empty = (x0 > x1c) || (y0 > y1c);
        n     = 0;
        if (!empty) begin
            for (int y = y0; y <= y1c; y++) begin
                for (int x = x0; x <= x1c; x++) begin
                    if (limit < 0 || n < limit) begin
                        lin       = y * 320 + x;
                        e.is_done = 1'b0;
                        e.we      = 4'(1 << (lin / 16384));
                        e.addr    = 14'(lin % 16384);
                        e.din     = color;
                        e.cyc     = k + 2 + n;
                        q.push_back(e);
                    end
                    n++;
                end
            end
        end
        if (limit < 0) begin
            e.is_done = 1'b1;
            e.we      = '0;
            e.addr    = '0;
            e.din     = 1'b0;
            e.cyc     = empty ? k + 1 : k + 2 + n;
            q.push_back(e);
        end
    endtask

    task automatic send(input int x0, input int x1, input int y0, input int y1,
                        input bit color, input int limit);
        int w;
        w = 0;
        @(negedge clk);
        while (!cmd_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        chk("ready_before_cmd", int'(cmd_ready), 1);
        cmd_x0    = x0[8:0];
        cmd_x1    = x1[8:0];
        cmd_y0    = y0[7:0];
        cmd_y1    = y1[7:0];
        cmd_color = color;
        cmd_valid = 1'b1;
        push_cmd(x0, x1, y0, y1, color, limit, cyc + 1);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 70000; i++) begin
            @(negedge clk);
            #1;
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        chk({name, "_done_seen"}, int'(seen), 1);
        if (seen) begin
            @(negedge clk);
            #1;
            chk({name, "_ready_after_done"}, int'(cmd_ready), 1);
            chk({name, "_busy_after_done"}, int'(busy), 0);
        end
    endtask

    initial begin
        int n0;
        bit hit;

        // Reset state
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_cmd_ready", int'(cmd_ready), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_fb_we", int'(fb_we), 0);
        chk("rst_fb_addr", int'(fb_addr), 0);
        chk("rst_fb_din", int'(fb_din), 0);
        reset = 1'b0;

        // Single pixel (5,7): lin 2245 in bank 0
        n0 = n_writes;
        send(5, 5, 7, 7, 1'b1, -1);
        wait_done("pixel");
        chk("pixel_writes", n_writes - n0, 1);
        chk("pixel_we", int'(last_we), 4'b0001);
        chk("pixel_addr", int'(last_addr), 2245);

        // 3x2 rectangle; a cmd_valid burst while busy must be ignored
        n0 = n_writes;
        send(0, 2, 0, 1, 1'b0, -1);
        cmd_x0 = 9'd100; cmd_x1 = 9'd110; cmd_y0 = 8'd50; cmd_y1 = 8'd60;
        cmd_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1 cmd_valid = 1'b0;
        wait_done("rect");
        chk("rect_writes", n_writes - n0, 6);
        chk("rect_last_addr", int'(last_addr), 322);

        // (64,51): lin 16384, first address of bank 1
        n0 = n_writes;
        send(64, 64, 51, 51, 1'b1, -1);
        wait_done("bank1");
        chk("bank1_writes", n_writes - n0, 1);
        chk("bank1_we", int'(last_we), 4'b0010);
        chk("bank1_addr", int'(last_addr), 0);

        // Clipped to (318,198)-(319,199); last lin 63999 in bank 3
        n0 = n_writes;
        send(318, 400, 198, 255, 1'b1, -1);
        wait_done("clip");
        chk("clip_writes", n_writes - n0, 4);
        chk("clip_we", int'(last_we), 4'b1000);
        chk("clip_addr", int'(last_addr), 14847);

        // Empty: x0 > x1
        n0 = n_writes;
        send(10, 5, 0, 0, 1'b1, -1);
        wait_done("empty");
        chk("empty_writes", n_writes - n0, 0);

        // Empty: x0 past the right edge
        n0 = n_writes;
        send(330, 340, 3, 4, 1'b1, -1);
        wait_done("offscreen");
        chk("offscreen_writes", n_writes - n0, 0);

        // Full-screen fill aborted by reset after 1000 writes
        n0 = n_writes;
        send(0, 319, 0, 199, 1'b1, 1000);
        hit = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            #1;
            if (n_writes - n0 >= 1000) begin
                hit = 1'b1;
                break;
            end
        end
        chk("abort_reached_1000", int'(hit), 1);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        chk("abort_fb_we", int'(fb_we), 0);
        chk("abort_ready", int'(cmd_ready), 1);
        repeat (10) @(negedge clk);
        chk("abort_writes", n_writes - n0, 1000);
        chk("abort_queue_empty", q.size(), 0);

        // Single pixel after the abort
        n0 = n_writes;
        send(5, 5, 7, 7, 1'b0, -1);
        wait_done("post_abort");
        chk("post_abort_writes", n_writes - n0, 1);
        chk("post_abort_addr", int'(last_addr), 2245);

        repeat (4) @(negedge clk);
        chk("final_queue_empty", q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
